// File: rtl/load_store_unit_if.sv
// ============================================================================
// Module      : load_store_unit_if
// Description : Request/response and data-memory bundle for the load/store
//               unit. The slave modport is the unit's view; the master
//               modport is the surrounding environment (execute stage plus
//               the word-only data memory).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  // request channel from execute
  logic                  reqValid;
  logic                  reqReady;
  logic                  reqWrite;
  logic [1:0]            reqSize;
  logic                  reqUnsigned;
  logic [ADDR_WIDTH-1:0] reqAddr;
  logic [31:0]           reqWdata;

  // completion channel back to execute
  logic                  respValid;
  logic [31:0]           respData;
  logic                  respFault;

  // word-only data memory port
  logic [ADDR_WIDTH-1:0] memAddress;
  logic [31:0]           memWriteData;
  logic                  memWriteEnable;
  logic                  memReadEnable;
  logic [31:0]           memReadData;

  modport master (
    output reqValid, reqWrite, reqSize, reqUnsigned, reqAddr, reqWdata,
    output memReadData,
    input  reqReady, respValid, respData, respFault,
    input  memAddress, memWriteData, memWriteEnable, memReadEnable
  );

  modport slave (
    input  reqValid, reqWrite, reqSize, reqUnsigned, reqAddr, reqWdata,
    input  memReadData,
    output reqReady, respValid, respData, respFault,
    output memAddress, memWriteData, memWriteEnable, memReadEnable
  );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : Byte/half/word load-store engine in front of a word-only data
//               memory. Sub-word stores are done as read-modify-write, loads
//               are lane-selected and sign/zero-extended, and each request
//               completes with a one-cycle respValid pulse.
//               Optional macro LSU_MISALIGN_TRAP_EN: when defined, misaligned
//               or illegal-size requests fault without touching memory; when
//               undefined, low address bits are ignored and size 11 is a word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] RMW_READ = 3'd2;
  localparam logic [2:0] WRITE    = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  logic [2:0]            state;
  logic [2:0]            state_next;

  // request captured at acceptance
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            size;
  logic                  write;
  logic                  zero_ext;
  logic [31:0]           wdata;

  logic [31:0]           merge_buf;
  logic [31:0]           resp_data;
  logic                  resp_fault;

  // acceptance-time decode of the incoming request
  logic                  req_fault;
  logic [1:0]            req_size_eff;

  // lane steering for the registered request
  logic [1:0]            lane;
  logic [1:0]            shift;
  logic [31:0]           lane_word;
  logic [31:0]           load_ext;
  logic [31:0]           mask_base;
  logic [31:0]           mask;
  logic [31:0]           insert;
  logic [31:0]           merged;

  wire accept = (state == IDLE) && bus.reqValid;

`ifdef LSU_MISALIGN_TRAP_EN
  // fault detection on the raw request; size 11 is always illegal
  always_comb begin
    req_size_eff = bus.reqSize;
    req_fault    = (bus.reqSize == 2'b11)
                || ((bus.reqSize == SIZE_HALF) && bus.reqAddr[0])
                || ((bus.reqSize == SIZE_WORD) && (bus.reqAddr[1:0] != 2'b00));
  end
`else
  // no trapping: illegal size collapses to word, low address bits are ignored
  always_comb begin
    req_size_eff = (bus.reqSize == 2'b11) ? SIZE_WORD : bus.reqSize;
    req_fault    = 1'b0;
  end
`endif

  // byte offset of the addressed item in memory order; halves drop addr[0]
  always_comb begin
    case (size)
      SIZE_BYTE: lane = addr[1:0];
      SIZE_HALF: lane = {addr[1], 1'b0};
      default:   lane = 2'b00;
    endcase
  end

  // convert the memory-order offset into a bit-lane shift (in bytes)
  generate
    if (BIG_ENDIAN) begin : g_big_endian
      // lower address sits in the more significant lane
      always_comb begin
        case (size)
          SIZE_BYTE: shift = 2'd3 - lane;
          SIZE_HALF: shift = 2'd2 - lane;
          default:   shift = 2'd0;
        endcase
      end
    end else begin : g_little_endian
      // byte n lives at bits 8n+7:8n
      always_comb begin
        shift = lane;
      end
    end
  endgenerate

  // load path: right-justify the addressed lane and extend it
  always_comb begin
    lane_word = bus.memReadData >> {shift, 3'b000};
    case (size)
      SIZE_BYTE: load_ext = zero_ext ? {24'h0, lane_word[7:0]}
                                     : {{24{lane_word[7]}}, lane_word[7:0]};
      SIZE_HALF: load_ext = zero_ext ? {16'h0, lane_word[15:0]}
                                     : {{16{lane_word[15]}}, lane_word[15:0]};
      default:   load_ext = lane_word;
    endcase
  end

  // store path: replace only the target lane of the merge buffer; for a word
  // the mask covers everything so the store data passes straight through
  always_comb begin
    case (size)
      SIZE_BYTE: mask_base = 32'h0000_00FF;
      SIZE_HALF: mask_base = 32'h0000_FFFF;
      default:   mask_base = 32'hFFFF_FFFF;
    endcase
    mask   = mask_base << {shift, 3'b000};
    insert = (wdata & mask_base) << {shift, 3'b000};
    merged = (merge_buf & ~mask) | insert;
  end

  // state register plus request capture, merge buffer and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      size       <= SIZE_BYTE;
      write      <= 1'b0;
      zero_ext   <= 1'b0;
      wdata      <= 32'h0;
      merge_buf  <= 32'h0;
      resp_data  <= 32'h0;
      resp_fault <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr     <= bus.reqAddr;
        size     <= req_size_eff;
        write    <= bus.reqWrite;
        zero_ext <= bus.reqUnsigned;
        wdata    <= bus.reqWdata;
      end
      if (state == RMW_READ) begin
        merge_buf <= bus.memReadData;
      end
      // response registers change only on entry to DONE, then hold
      if (accept && req_fault) begin
        resp_data  <= 32'h0;
        resp_fault <= 1'b1;
      end
      if (state == LOAD) begin
        resp_data  <= load_ext;
        resp_fault <= 1'b0;
      end
      if (state == WRITE) begin
        resp_data  <= 32'h0;
        resp_fault <= 1'b0;
      end
    end
  end

  // next-state sequencing; DONE always returns through IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.reqValid) begin
          if (req_fault)                     state_next = DONE;
          else if (!bus.reqWrite)            state_next = LOAD;
          else if (req_size_eff == SIZE_WORD) state_next = WRITE;
          else                               state_next = RMW_READ;
        end
      end
      LOAD:     state_next = DONE;
      RMW_READ: state_next = WRITE;
      WRITE:    state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // memory strobes and handshakes decode from registered state only
  always_comb begin
    bus.reqReady       = (state == IDLE);
    bus.respValid      = (state == DONE);
    bus.memReadEnable  = ((state == LOAD) && !write) || (state == RMW_READ);
    bus.memWriteEnable = (state == WRITE) && write;
    bus.memAddress     = '0;
    bus.memWriteData   = 32'h0;
    if ((state == LOAD) || (state == RMW_READ) || (state == WRITE)) begin
      bus.memAddress = {addr[ADDR_WIDTH-1:2], 2'b00};
    end
    if (state == WRITE) begin
      bus.memWriteData = merged;
    end
  end

  assign bus.respData  = resp_data;
  assign bus.respFault = resp_fault;

endmodule

`default_nettype wire
